muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide controller attached to the execute stage. It accepts one M-extension operation per request with post-forwarding operands and sequences a shared 33-bit add/sub datapath through 32 iterations. While it works, it holds the IF/ID/EX pipeline with a stall. It returns a 32-bit result with a one-cycle done pulse, which the execute stage muxes in place of the ALU result into the EX/MEM register.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_addsub.sv | 20 ++
 rtl/muldiv_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 5;

   localparam logic [CNT_W-1:0] LAST_CNT = 5'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   // Two's-complement magnitude; 0x80000000 yields 2^31 read as unsigned.
   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
      abs_val = neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the multiply accumulate and the divide trial subtract.
module muldiv_addsub
   import muldiv_pkg::*;
(
   input  logic [XLEN:0] a_i,
   input  logic [XLEN:0] b_i,
   input  logic          sub_i,
   output logic [XLEN:0] sum_o,
   output logic          cout_o
);

   logic [XLEN+1:0] full_s;
   logic [XLEN:0]   b_eff_s;

   assign b_eff_s = sub_i ? ~b_i : b_i;
   assign full_s  = {1'b0, a_i} + {1'b0, b_eff_s} + {{(XLEN+1){1'b0}}, sub_i};
   assign sum_o   = full_s[XLEN:0];
   assign cout_o  = full_s[XLEN+1];

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: LSB-first shift-add multiply and restoring
// divide over one shared 33-bit add/sub, stalling the front of the pipeline while busy.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] operand1_i,
   input  logic [XLEN-1:0] operand2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        f3_q;
   logic [XLEN:0]     hi_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   opb_q;
   logic              neg_q;
   logic              sgn1_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   logic              op1_signed_s, op2_signed_s, s1_s, s2_s;
   logic [XLEN-1:0]   mag1_s, mag2_s;
   logic              div0_s, ovf_s, accept_s;
   logic [XLEN-1:0]   special_res_d;

   logic [XLEN:0]     shifted_s, add_a_s, add_b_s, add_sum_s, mul_t_s;
   logic              add_cout_s;
   logic [XLEN:0]     hi_step_d;
   logic [XLEN-1:0]   lo_step_d;

   logic [2*XLEN-1:0] prod_s, prod_fix_s;
   logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_res_d;

   // Operand decode at accept: signedness, magnitudes and the bypass cases.
   always_comb begin
      op1_signed_s = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                     (funct3_i == F3_DIV) || (funct3_i == F3_REM);
      op2_signed_s = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) ||
                     (funct3_i == F3_DIV) || (funct3_i == F3_REM);
      s1_s   = op1_signed_s & operand1_i[XLEN-1];
      s2_s   = op2_signed_s & operand2_i[XLEN-1];
      mag1_s = abs_val(operand1_i, s1_s);
      mag2_s = abs_val(operand2_i, s2_s);
      div0_s = funct3_i[2] && (operand2_i == {XLEN{1'b0}});
      ovf_s  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
               (operand1_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand2_i == {XLEN{1'b1}});
      special_res_d = {XLEN{1'b0}};
      if (div0_s) begin
         special_res_d = funct3_i[1] ? operand1_i : {XLEN{1'b1}};
      end else if (ovf_s) begin
         special_res_d = funct3_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
         special_res_d = {XLEN{1'b0}};
      end
   end

   assign accept_s = start_i && !flush_i;

   muldiv_addsub u_addsub (
      .a_i    (add_a_s),
      .b_i    (add_b_s),
      .sub_i  (f3_q[2]),
      .sum_o  (add_sum_s),
      .cout_o (add_cout_s)
   );

   // One iteration: divide shifts the remainder left before the trial subtract,
   // multiply adds then shifts the 65-bit {hi,lo} pair right.
   always_comb begin
      shifted_s = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
      add_b_s   = {1'b0, opb_q};
      mul_t_s   = lo_q[0] ? add_sum_s : hi_q;
      if (f3_q[2]) begin
         add_a_s   = shifted_s;
         hi_step_d = add_cout_s ? add_sum_s : shifted_s;
         lo_step_d = {lo_q[XLEN-2:0], add_cout_s};
      end else begin
         add_a_s   = hi_q;
         hi_step_d = {1'b0, mul_t_s[XLEN:1]};
         lo_step_d = {mul_t_s[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign correction and result selection.
   always_comb begin
      prod_s     = {hi_q[XLEN-1:0], lo_q};
      prod_fix_s = neg_q ? (~prod_s + 64'd1) : prod_s;
      quo_fix_s  = neg_q ? (~lo_q + 32'd1) : lo_q;
      rem_fix_s  = sgn1_q ? (~hi_q[XLEN-1:0] + 32'd1) : hi_q[XLEN-1:0];
      case (f3_q)
         F3_MUL:                        fix_res_d = prod_fix_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  fix_res_d = prod_fix_s[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:               fix_res_d = quo_fix_s;
         F3_REM, F3_REMU:               fix_res_d = rem_fix_s;
         default:                       fix_res_d = {XLEN{1'b0}};
      endcase
   end

   // Sequencer FSM with registered done/result.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         f3_q     <= 3'b000;
         hi_q     <= {(XLEN+1){1'b0}};
         lo_q     <= {XLEN{1'b0}};
         opb_q    <= {XLEN{1'b0}};
         neg_q    <= 1'b0;
         sgn1_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= {XLEN{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (accept_s) begin
                  f3_q   <= funct3_i;
                  neg_q  <= s1_s ^ s2_s;
                  sgn1_q <= s1_s;
                  cnt_q  <= {CNT_W{1'b0}};
                  hi_q   <= {(XLEN+1){1'b0}};
                  lo_q   <= funct3_i[2] ? mag1_s : mag2_s;
                  opb_q  <= funct3_i[2] ? mag2_s : mag1_s;
                  if (div0_s || ovf_s) begin
                     result_q <= special_res_d;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q <= CALC;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               if (flush_i) begin
                  state_q <= IDLE;
               end else begin
                  hi_q  <= hi_step_d;
                  lo_q  <= lo_step_d;
                  cnt_q <= cnt_q + 5'd1;
                  state_q <= (cnt_q == LAST_CNT) ? FIX : CALC;
               end
            end
            FIX: begin
               if (flush_i) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= fix_res_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign stall_o  = reset_i && (((state_q == IDLE) && accept_s) ||
                                 (state_q == CALC) || (state_q == FIX));
   assign busy_o   = (state_q != IDLE);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomised bench for muldiv_sequencer with a result scoreboard.
module tb_muldiv_sequencer;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] operand1_i;
   logic [31:0] operand2_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res;

   muldiv_sequencer dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .funct3_i   (funct3_i),
      .operand1_i (operand1_i),
      .operand2_i (operand2_i),
      .flush_i    (flush_i),
      .stall_o    (stall_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, p;
      logic        [63:0] up;
      logic signed [31:0] sa32, sb32;
      logic               ovf;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ub   = {32'd0, b};
      sa32 = a;
      sb32 = b;
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      ref_op = 32'd0;
      case (f3)
         3'd0: begin p = sa * sb; ref_op = p[31:0]; end
         3'd1: begin p = sa * sb; ref_op = p[63:32]; end
         3'd2: begin p = sa * ub; ref_op = p[63:32]; end
         3'd3: begin up = {32'd0, a} * {32'd0, b}; ref_op = up[63:32]; end
         3'd4: ref_op = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa32 / sb32));
         3'd5: ref_op = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: ref_op = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa32 % sb32));
         default: ref_op = (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // Drive one op from an IDLE cycle, track stall length and done cycle, pop the scoreboard.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input bit special);
      int stall_cnt;
      int done_cyc;
      logic [31:0] exp;
      exp_q.push_back(exp_res);
      start_i    = 1'b1;
      funct3_i   = f3;
      operand1_i = a;
      operand2_i = b;
      stall_cnt  = 0;
      done_cyc   = 0;
      for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
         #1;
         if (stall_o) stall_cnt++;
         if (done_o) begin
            done_cyc = c;
            exp = exp_q.pop_front();
            check({tag, " result"}, result_o, exp);
            last_res = exp;
         end
         @(negedge clk_i);
      end
      start_i = 1'b0;
      check({tag, " stall cycles"}, 32'(stall_cnt), special ? 32'd1 : 32'd34);
      check({tag, " done cycle"}, 32'(done_cyc), special ? 32'd2 : 32'd35);
      #1;
      check({tag, " done pulse width"}, {31'd0, done_o}, 32'd0);
   endtask

   initial begin
      int done_seen;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      reset_i    = 1'b0;
      start_i    = 1'b0;
      flush_i    = 1'b0;
      funct3_i   = 3'd0;
      operand1_i = 32'd0;
      operand2_i = 32'd0;
      last_res   = 32'd0;
      repeat (3) @(negedge clk_i);
      #1;
      check("reset stall", {31'd0, stall_o}, 32'd0);
      check("reset busy", {31'd0, busy_o}, 32'd0);
      check("reset done", {31'd0, done_o}, 32'd0);
      check("reset result", result_o, 32'd0);
      reset_i = 1'b1;
      @(negedge clk_i);

      run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
      run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
      run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
      run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b1);
      run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

      // Flush in the 10th CALC cycle (cycle 11 counting the accept cycle as 1).
      start_i    = 1'b1;
      funct3_i   = 3'd0;
      operand1_i = 32'd5;
      operand2_i = 32'd6;
      repeat (10) @(negedge clk_i);
      flush_i = 1'b1;
      #1;
      check("flush busy in CALC", {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
      flush_i = 1'b0;
      start_i = 1'b0;
      #1;
      check("flush stall", {31'd0, stall_o}, 32'd0);
      check("flush busy", {31'd0, busy_o}, 32'd0);
      check("flush result held", result_o, last_res);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (done_o) done_seen++;
      end
      check("flush no done", 32'(done_seen), 32'd0);
      check("flush result still held", result_o, last_res);
      run_op("MUL 3*4 after flush", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

      // Reset in the middle of CALC.
      start_i    = 1'b1;
      funct3_i   = 3'd0;
      operand1_i = 32'd7;
      operand2_i = 32'd9;
      repeat (14) @(negedge clk_i);
      reset_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk_i);
      #1;
      check("midreset stall", {31'd0, stall_o}, 32'd0);
      check("midreset busy", {31'd0, busy_o}, 32'd0);
      check("midreset done", {31'd0, done_o}, 32'd0);
      check("midreset result", result_o, 32'd0);
      reset_i = 1'b1;
      run_op("DIVU 9/3 after reset", 3'd5, 32'd9, 32'd3, 32'd3, 1'b0);

      for (int i = 0; i < 8; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : $urandom;
         run_op("random op", rf3, ra, rb, ref_op(rf3, ra, rb), rf3[2] && (rb == 32'd0));
      end

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
